// File: rtl/cic_pkg.sv
// Shared CIC helpers for cic_decim and cic_interp: the internal-width and gain-shift
// arithmetic, and the legal ranges for the rate and stage-count parameters.
package cic_pkg;

  localparam int CIC_RATE_MIN   = 2;
  localparam int CIC_RATE_MAX   = 64;
  localparam int CIC_STAGES_MIN = 1;
  localparam int CIC_STAGES_MAX = 6;

  // The gain of the filter is RATE^STAGES. RATE is a power of two, so this shift removes it.
  function automatic int cic_shift(input int rate, input int stages);
    return stages * $clog2(rate);
  endfunction

  // Bit growth is the log2 of the gain.
  function automatic int cic_iw(input int width, input int rate, input int stages);
    return width + cic_shift(rate, stages);
  endfunction

  function automatic bit cic_params_ok(input int rate, input int stages);
    return (rate >= CIC_RATE_MIN) && (rate <= CIC_RATE_MAX) &&
           ((rate & (rate - 1)) == 0) &&
           (stages >= CIC_STAGES_MIN) && (stages <= CIC_STAGES_MAX);
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// Comb stage: a registered differentiator y[n] = x[n] - x[n-1] that is IW bits wide.
// Latency: 1 cycle when i_en is high. The stage holds its state when i_en is low.
// Backpressure: none. The enable comes from the decimation strobe pipeline.
module cic_comb_stage #(
  parameter int IW = 25
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_en,
  input  logic [IW-1:0] i_data,
  output logic [IW-1:0] o_data
);

  logic [IW-1:0] dly_q, dly_d;
  logic [IW-1:0] diff_q, diff_d;

  always_comb begin
    dly_d  = dly_q;
    diff_d = diff_q;
    if (i_en) begin
      diff_d = i_data - dly_q;
      dly_d  = i_data;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      dly_q  <= '0;
      diff_q <= '0;
    end else begin
      dly_q  <= dly_d;
      diff_q <= diff_d;
    end
  end

  assign o_data = diff_q;

endmodule

// File: rtl/cic_decim.sv
// CIC decimator by RATE with STAGES stages. Defining CIC_DECIM_ROUND_EN selects round-half-up plus saturation.
// Latency: o_out_valid pulses STAGES+1 cycles after the edge that accepts the RATE-th valid input.
// Backpressure: none. A valid input may arrive on every cycle, and cycles without a valid input only stall the integrators.
module cic_decim
  import cic_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int RATE   = 8,
  parameter int STAGES = 3
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic             i_in_valid,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_valid
);

  localparam int SHIFT = cic_shift(RATE, STAGES);
  localparam int IW    = cic_iw(WIDTH, RATE, STAGES);
  localparam int CW    = $clog2(RATE);
  localparam logic [CW-1:0] PHASE_LAST = CW'(RATE - 1);

  if (!cic_params_ok(RATE, STAGES)) begin : g_bad_params
    $error("cic_decim: RATE must be a power of two in 2..64 and STAGES must be in 1..6");
  end

  logic [IW-1:0]     integ_q [STAGES];
  logic [IW-1:0]     integ_d [STAGES];
  logic [CW-1:0]     phase_q, phase_d;
  logic [STAGES:0]   stb_q, stb_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              vld_q;
  logic [IW-1:0]     in_ext;

  assign in_ext = {{SHIFT{i_in_data[WIDTH-1]}}, i_in_data};

  // Each stage adds the previous stage's register, so the chain is pipelined by one sample per stage.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      integ_d[k] = integ_q[k];
    end
    if (i_in_valid) begin
      integ_d[0] = integ_q[0] + in_ext;
      for (int k = 1; k < STAGES; k++) begin
        integ_d[k] = integ_q[k] + integ_q[k-1];
      end
    end
  end

  always_comb begin
    phase_d  = phase_q;
    stb_d    = {stb_q[STAGES-1:0], 1'b0};
    if (i_in_valid) begin
      if (phase_q == PHASE_LAST) begin
        phase_d  = '0;
        stb_d[0] = 1'b1;
      end else begin
        phase_d  = phase_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int k = 0; k < STAGES; k++) begin
        integ_q[k] <= '0;
      end
      phase_q <= '0;
      stb_q   <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        integ_q[k] <= integ_d[k];
      end
      phase_q <= phase_d;
      stb_q   <= stb_d;
    end
  end

  // Comb g advances one cycle after comb g-1, tracked by stb_q[g].
  logic [IW-1:0] comb_dat [STAGES+1];
  assign comb_dat[0] = integ_q[STAGES-1];

  for (genvar g = 0; g < STAGES; g++) begin : g_comb
    cic_comb_stage #(
      .IW(IW)
    ) u_comb (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_en    (stb_q[g]),
      .i_data  (comb_dat[g]),
      .o_data  (comb_dat[g+1])
    );
  end

`ifdef CIC_DECIM_ROUND_EN
  localparam logic [IW:0] HALF_LSB = (IW+1)'(1) << (SHIFT - 1);
  logic [IW:0]    rnd_sum;
  logic [WIDTH:0] rnd_val;

  // One extra bit keeps the rounding add from overflowing before saturation.
  assign rnd_sum = {comb_dat[STAGES][IW-1], comb_dat[STAGES]} + HALF_LSB;
  assign rnd_val = rnd_sum[IW:SHIFT];

  always_comb begin
    out_d = rnd_val[WIDTH-1:0];
    if (rnd_val[WIDTH] != rnd_val[WIDTH-1]) begin
      out_d = rnd_val[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  // The arithmetic shift by SHIFT followed by truncation to WIDTH leaves exactly the top WIDTH bits.
  assign out_d = comb_dat[STAGES][IW-1 -: WIDTH];
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= stb_q[STAGES];
      if (stb_q[STAGES]) begin
        out_q <= out_d;
      end
    end
  end

  assign o_out_data  = out_q;
  assign o_out_valid = vld_q;

endmodule

// File: tb/tb_cic_decim.sv
// Randomised and directed bench for cic_decim (WIDTH=16, RATE=8, STAGES=3) against a sample-domain reference model.
module tb_cic_decim;

  localparam int WIDTH  = 16;
  localparam int RATE   = 8;
  localparam int STAGES = 3;
  localparam int SH     = 9;
  localparam int IW     = WIDTH + SH;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    in_vld = 1'b0;
  logic signed [WIDTH-1:0] in_dat = '0;
  logic signed [WIDTH-1:0] out_dat;
  logic                    out_vld;

  cic_decim #(.WIDTH(WIDTH), .RATE(RATE), .STAGES(STAGES)) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_in_data   (in_dat),
    .i_in_valid  (in_vld),
    .o_out_data  (out_dat),
    .o_out_valid (out_vld)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: the sample-domain filter with IW-bit wrapping arithmetic
  longint integ [STAGES];
  longint dly   [STAGES];
  int     phase;
  longint exp_q [$];

  function automatic longint wrap(input longint x);
    longint m;
    longint r;
    m = (longint'(1) << IW) - 1;
    r = x & m;
    if (r[IW-1]) r = r - (longint'(1) << IW);
    return r;
  endfunction

  function automatic longint scale(input longint v);
    longint r;
    logic signed [WIDTH-1:0] t;
`ifdef CIC_DECIM_ROUND_EN
    r = (v + (longint'(1) << (SH - 1))) >>> SH;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`else
    r = v >>> SH;
`endif
    t = r[WIDTH-1:0];
    return longint'(t);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < STAGES; k++) begin
      integ[k] = 0;
      dly[k]   = 0;
    end
    phase = 0;
    exp_q.delete();
  endtask

  task automatic model_sample(input longint x);
    longint v;
    longint d;
    for (int k = STAGES - 1; k >= 1; k--) integ[k] = wrap(integ[k] + integ[k-1]);
    integ[0] = wrap(integ[0] + x);
    if (phase == RATE - 1) begin
      phase = 0;
      v = integ[STAGES-1];
      for (int k = 0; k < STAGES; k++) begin
        d      = wrap(v - dly[k]);
        dly[k] = v;
        v      = d;
      end
      exp_q.push_back(scale(v));
    end else begin
      phase++;
    end
  endtask

  // Observation of output pulses
  int     pulses = 0;
  longint vals [$];
  int     pcyc [$];

  always @(negedge clk) begin
    if (out_vld === 1'b1) begin
      pulses++;
      vals.push_back(longint'(out_dat));
      pcyc.push_back(cyc);
      if (exp_q.size() == 0) check("spurious_pulse", 1, 0);
      else check("out_data", longint'(out_dat), exp_q.pop_front());
    end
  end

  task automatic clear_obs();
    pulses = 0;
    vals.delete();
    pcyc.delete();
  endtask

  // Drive one cycle. After the task returns, cyc is the edge that sampled these inputs.
  task automatic step(input bit v, input longint d);
    in_vld = v;
    in_dat = d[WIDTH-1:0];
    if (v && !rst) model_sample(longint'(in_dat));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) step(1'b0, 0);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic dc_run(input string tag, input longint dc, input int n, input int gap);
    do_reset(3);
    clear_obs();
    for (int i = 0; i < n; i++) begin
      step(1'b1, dc);
      for (int j = 1; j < gap; j++) step(1'b0, 0);
    end
    for (int i = 0; i < 30; i++) step(1'b0, 0);
    check({tag, "_pulses"}, pulses, n / RATE);
    for (int i = 3; i < vals.size(); i++) check({tag, "_settled"}, vals[i], dc);
    for (int i = 1; i < pcyc.size(); i++) check({tag, "_spacing"}, pcyc[i] - pcyc[i-1], gap * RATE);
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int e8;
    int nv;
    logic signed [WIDTH-1:0] r;
    longint d;

    model_clear();
    @(posedge clk);
    #1;
    do_reset(4);
    check("reset_valid", out_vld, 0);
    check("reset_data", longint'(out_dat), 0);

    // Idle input produces no pulses.
    do_reset(3);
    clear_obs();
    for (int i = 0; i < 1000; i++) step(1'b0, 0);
    check("idle_pulses", pulses, 0);

    dc_run("dc_pos", 1000, 800, 1);
    dc_run("dc_neg", -2000, 800, 1);
    dc_run("fs_pos", 32767, 160, 1);
    dc_run("fs_neg", -32768, 160, 1);
    dc_run("gapped", 1000, 240, 3);

    // Latency: back-to-back valid inputs from the first edge after reset.
    do_reset(3);
    clear_obs();
    for (int i = 0; i < RATE; i++) step(1'b1, $urandom_range(0, 4000));
    e8 = cyc;
    for (int i = 0; i < 20; i++) step(1'b0, 0);
    check("lat_pulses", pulses, 1);
    if (pulses >= 1) check("lat_cycle", pcyc[0] - e8, STAGES + 1);

    // A reset in the middle of a run discards the partial block.
    do_reset(3);
    clear_obs();
    for (int i = 0; i < 5; i++) step(1'b1, $urandom_range(0, 4000));
    do_reset(10);
    check("midrst_valid", out_vld, 0);
    check("midrst_data", longint'(out_dat), 0);
    for (int i = 0; i < RATE; i++) step(1'b1, $urandom_range(0, 4000));
    e8 = cyc;
    for (int i = 0; i < 20; i++) step(1'b0, 0);
    check("midrst_pulses", pulses, 1);
    if (pulses >= 1) check("midrst_cycle", pcyc[0] - e8, STAGES + 1);

    // Random data, including full-scale extremes, with random gaps in the valid input.
    do_reset(3);
    clear_obs();
    nv = 0;
    for (int i = 0; i < 1600; i++) begin
      case ($urandom_range(0, 7))
        0:       d = 32767;
        1:       d = -32768;
        default: begin r = 16'($urandom); d = longint'(r); end
      endcase
      if ($urandom_range(0, 3) != 0) begin
        step(1'b1, d);
        nv++;
      end else begin
        step(1'b0, 0);
      end
    end
    for (int i = 0; i < 30; i++) step(1'b0, 0);
    check("rand_pulses", pulses, nv / RATE);
    check("rand_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cic_decim.md
CIC_DECIM -- requirements
Module: cic_decim

Interface
REQ-001 Parameter WIDTH, default 16: input and output sample width, signed two's complement.
REQ-002 Parameter RATE, default 8: decimation factor; power of two, 2..64.
REQ-003 Parameter STAGES, default 3: number of integrator and comb stages, 1..6; differential delay fixed at 1.
REQ-004 Port i_clock  input  1: sole clock; all logic on rising edge.
REQ-005 Port i_reset  input  1: synchronous, active-high reset.
REQ-006 Port i_in_data  input  WIDTH: input sample, signed.
REQ-007 Port i_in_valid  input  1: qualifies i_in_data; may be high every cycle; no backpressure.
REQ-008 Port o_out_data  output  WIDTH: decimated output sample, signed.
REQ-009 Port o_out_valid  output  1: single-cycle pulse qualifying o_out_data.

Function
REQ-010 Internal width SHALL be IW = WIDTH + STAGES*log2(RATE); all integrator and comb registers are IW bits, signed.
REQ-011 Integrator arithmetic SHALL wrap modulo 2^IW; overflow is intentional and corrected by the combs.
REQ-012 Integrator chain SHALL be pipelined, one register per stage; every stage updates only on cycles with i_in_valid=1 (stage k += stage k-1 register; stage 1 += sign-extended i_in_data).
REQ-013 A phase counter 0..RATE-1 SHALL increment on each valid input and wrap to 0 at RATE-1.
REQ-014 On edge E0 sampling i_in_valid=1 with counter=RATE-1, a decimation strobe SHALL be registered; at E0+1 the last-integrator register value is loaded into comb stage 1.
REQ-015 Each comb stage SHALL compute x[n]-x[n-1] (previous decimated value) and register it, one cycle per stage, advancing only on the strobe pipeline.
REQ-016 Output SHALL be the comb result arithmetically right-shifted by STAGES*log2(RATE) (gain RATE^STAGES removed), truncated to WIDTH bits.
REQ-017 o_out_valid SHALL pulse high for exactly one cycle following edge E0+STAGES+1; o_out_data holds its value until the next pulse.
REQ-018 Exactly one output SHALL be produced per RATE valid inputs; gaps in i_in_valid change only timing, never values.
REQ-019 Cycles with i_in_valid=0 SHALL not change the integrators or the counter; the comb/output pipeline keeps draining.

Reset
REQ-020 While i_reset=1: all integrators, combs, delay registers, counter and strobe pipeline SHALL clear to 0; o_out_valid=0, o_out_data=0.
REQ-021 Reset mid-operation SHALL discard in-flight decimation strobes; no o_out_valid pulse is produced from pre-reset inputs.
REQ-022 The first output after reset SHALL follow the RATE-th valid input after reset deassertion.

Configuration
REQ-023 With CIC_DECIM_ROUND_EN defined: add 2^(shift-1) before the shift, round half up, saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-024 Without CIC_DECIM_ROUND_EN: plain truncating arithmetic shift, no saturation logic.

Structure
REQ-025 Package cic_pkg SHALL hold the clog2-based internal-width function, the shift constant computation and the parameter-range limits, shared with cic_interp.
REQ-026 Sub-module cic_comb_stage (IW-wide registered differentiator with enable) SHALL be instantiated STAGES times via generate; integrators stay inline.

Verification (WIDTH=16, RATE=8, STAGES=3)
REQ-027 Idle: reset, then 1000 cycles with i_in_valid=0 -> zero o_out_valid pulses.
REQ-028 DC: 800 consecutive valid samples of 1000 -> exactly 100 pulses; every pulse after settling (4th onward) outputs 1000; repeat with -2000 -> -2000.
REQ-029 Full scale: DC 32767 -> settled output 32767; DC -32768 -> -32768 (no wrap error).
REQ-030 Gapped input: DC 1000 with valid every 3rd cycle, 240 samples -> 30 pulses, settled value 1000, pulse spacing 24 cycles.
REQ-031 Reset mid-run: 5 valid inputs, reset for 10 cycles, then 8 valid inputs -> exactly one pulse, exactly STAGES+1 cycles after the 8th valid edge.
REQ-032 Latency: after reset, 8 back-to-back valid inputs at edges 1..8 -> o_out_valid high only in the cycle after edge 12.
